// File: rtl/ysyx_23060278_ifu.sv
// ysyx_23060278_ifu: instruction fetch unit issuing one memory read per core pc request, with sticky error trapping
module ysyx_23060278_ifu #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        pc_wen,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        fetch_err,
    output logic [1:0]  err_cause
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;
    state_t      state, state_n;
    logic [31:0] cnt, cnt_inc;
    logic [1:0]  cause_n;
    logic        tmo;
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 32'd1;
    assign tmo     = (TIMEOUT != 0) && (cnt_inc >= TIMEOUT);
    always_comb begin
        state_n = state;
        cause_n = err_cause;
        case (state)
            IDLE: if (pc_valid) begin
                state_n = (pc[1:0] != 2'd0) ? ERR : REQ;
                cause_n = (pc[1:0] != 2'd0) ? 2'd1 : err_cause;
            end
            REQ: if (mem_req_ready) state_n = WAIT;
                 else if (tmo) begin
                     state_n = ERR;
                     cause_n = 2'd3;
                 end
            // a completed handshake wins over a timeout in the same cycle
            WAIT: if (mem_rsp_valid) begin
                state_n = mem_rsp_err ? ERR : DONE;
                cause_n = mem_rsp_err ? 2'd2 : err_cause;
            end else if (tmo) begin
                state_n = ERR;
                cause_n = 2'd3;
            end
            DONE: state_n = IDLE;
            default: state_n = ERR;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            inst         <= NOP_INST;
            mem_req_addr <= 32'd0;
            cnt          <= 32'd0;
            err_cause    <= 2'd0;
        end else begin
            state     <= state_n;
            err_cause <= cause_n;
            if (state == IDLE && pc_valid && pc[1:0] == 2'd0) begin
                mem_req_addr <= pc;
                cnt          <= 32'd0;
            end
            if (state == REQ || state == WAIT) cnt <= cnt_inc;
            if (state == WAIT && mem_rsp_valid && !mem_rsp_err) inst <= mem_rsp_data;
        end
    end
    assign mem_req_valid = state == REQ;
    assign mem_rsp_ready = state == WAIT;
    assign inst_valid    = state == DONE;
    assign pc_wen        = state == DONE;
    assign fetch_err     = state == ERR;
endmodule

// File: tb/tb_ysyx_23060278_ifu.sv
// tb_ysyx_23060278_ifu: directed checks of fetch timing, stalls, error trapping, timeout and reset
module tb_ysyx_23060278_ifu;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] pc, inst, mem_req_addr, mem_rsp_data;
    logic pc_valid, inst_valid, pc_wen, mem_req_valid, mem_req_ready;
    logic mem_rsp_valid, mem_rsp_ready, mem_rsp_err, fetch_err;
    logic [1:0] err_cause;

    logic [31:0] t_pc, t_inst, t_mem_req_addr, t_mem_rsp_data;
    logic t_pc_valid, t_inst_valid, t_pc_wen, t_mem_req_valid, t_mem_req_ready;
    logic t_mem_rsp_valid, t_mem_rsp_ready, t_mem_rsp_err, t_fetch_err;
    logic [1:0] t_err_cause;

    ysyx_23060278_ifu dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .inst(inst),
        .inst_valid(inst_valid), .pc_wen(pc_wen), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .fetch_err(fetch_err), .err_cause(err_cause)
    );

    ysyx_23060278_ifu #(.TIMEOUT(8)) dut_t (
        .clk(clk), .rst(rst), .pc(t_pc), .pc_valid(t_pc_valid), .inst(t_inst),
        .inst_valid(t_inst_valid), .pc_wen(t_pc_wen), .mem_req_valid(t_mem_req_valid),
        .mem_req_ready(t_mem_req_ready), .mem_req_addr(t_mem_req_addr),
        .mem_rsp_valid(t_mem_rsp_valid), .mem_rsp_ready(t_mem_rsp_ready),
        .mem_rsp_data(t_mem_rsp_data), .mem_rsp_err(t_mem_rsp_err),
        .fetch_err(t_fetch_err), .err_cause(t_err_cause)
    );

    int vec = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " inst"}, inst, 32'h00000013);
        chk({tag, " inst_valid"}, inst_valid, 0);
        chk({tag, " pc_wen"}, pc_wen, 0);
        chk({tag, " req_valid"}, mem_req_valid, 0);
        chk({tag, " rsp_ready"}, mem_rsp_ready, 0);
        chk({tag, " req_addr"}, mem_req_addr, 0);
        chk({tag, " fetch_err"}, fetch_err, 0);
        chk({tag, " err_cause"}, err_cause, 0);
    endtask

    initial begin
        pc = 0; pc_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0; mem_rsp_err = 0;
        t_pc = 32'h80000000; t_pc_valid = 0; t_mem_req_ready = 0; t_mem_rsp_valid = 0;
        t_mem_rsp_data = 0; t_mem_rsp_err = 0;
        rst = 1'b1;
        tick();
        do_reset();
        chk_reset("rst");

        // zero-wait fetch
        pc = 32'h80000000; pc_valid = 1; mem_req_ready = 1;
        tick();
        pc_valid = 0;
        chk("t1 c1 req_valid", mem_req_valid, 1);
        chk("t1 c1 addr", mem_req_addr, 32'h80000000);
        chk("t1 c1 inst_valid", inst_valid, 0);
        tick();
        chk("t1 c2 rsp_ready", mem_rsp_ready, 1);
        chk("t1 c2 req_valid", mem_req_valid, 0);
        chk("t1 c2 inst_valid", inst_valid, 0);
        mem_rsp_valid = 1; mem_rsp_data = 32'h00500093;
        tick();
        mem_rsp_valid = 0;
        chk("t1 c3 inst_valid", inst_valid, 1);
        chk("t1 c3 pc_wen", pc_wen, 1);
        chk("t1 c3 inst", inst, 32'h00500093);
        tick();
        chk("t1 c4 inst_valid", inst_valid, 0);
        chk("t1 c4 pc_wen", pc_wen, 0);
        chk("t1 c4 inst hold", inst, 32'h00500093);

        // wait states with pc changing mid-fetch
        mem_req_ready = 0; pc = 32'h80000000; pc_valid = 1;
        tick();
        pc = 32'h80000010;
        for (int i = 0; i < 4; i++) begin
            chk("t2 req_valid stall", mem_req_valid, 1);
            chk("t2 addr stall", mem_req_addr, 32'h80000000);
            tick();
        end
        chk("t2 req_valid accept", mem_req_valid, 1);
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        for (int i = 0; i < 6; i++) begin
            chk("t2 rsp_ready wait", mem_rsp_ready, 1);
            chk("t2 inst_valid wait", inst_valid, 0);
            chk("t2 addr wait", mem_req_addr, 32'h80000000);
            tick();
        end
        mem_rsp_valid = 1; mem_rsp_data = 32'h00A00113;
        tick();
        mem_rsp_valid = 0;
        chk("t2 inst_valid", inst_valid, 1);
        chk("t2 inst", inst, 32'h00A00113);
        tick();
        chk("t2 inst_valid once", inst_valid, 0);
        tick();
        pc_valid = 0;
        chk("t2 next addr", mem_req_addr, 32'h80000010);
        chk("t2 next req_valid", mem_req_valid, 1);
        mem_req_ready = 1;
        tick();
        mem_rsp_valid = 1; mem_rsp_data = 32'h00310193;
        tick();
        mem_rsp_valid = 0;
        chk("t2 next inst", inst, 32'h00310193);
        chk("t2 next inst_valid", inst_valid, 1);
        tick();

        // misaligned pc
        do_reset();
        pc = 32'h80000002; pc_valid = 1;
        tick();
        pc = 32'h80000000;
        chk("t3 fetch_err", fetch_err, 1);
        chk("t3 cause", err_cause, 1);
        chk("t3 req_valid", mem_req_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3 sticky err", fetch_err, 1);
            chk("t3 sticky cause", err_cause, 1);
            chk("t3 no req", mem_req_valid, 0);
        end
        pc_valid = 0;

        // bus error
        do_reset();
        chk("t4 err cleared", fetch_err, 0);
        pc_valid = 1; mem_req_ready = 1;
        tick();
        pc_valid = 0;
        tick();
        mem_rsp_valid = 1; mem_rsp_err = 1; mem_rsp_data = 32'hDEADBEEF;
        tick();
        mem_rsp_valid = 0; mem_rsp_err = 0;
        chk("t4 fetch_err", fetch_err, 1);
        chk("t4 cause", err_cause, 2);
        chk("t4 inst", inst, 32'h00000013);
        chk("t4 inst_valid", inst_valid, 0);
        tick();
        chk("t4 sticky cause", err_cause, 2);
        chk("t4 no req", mem_req_valid, 0);
        chk("t4 no inst_valid", inst_valid, 0);

        // timeout, TIMEOUT=8, memory silent
        do_reset();
        t_pc_valid = 1;
        tick();
        t_pc_valid = 0;
        chk("t5 in req", t_mem_req_valid, 1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("t5 no err yet", t_fetch_err, 0);
        end
        tick();
        chk("t5 fetch_err", t_fetch_err, 1);
        chk("t5 cause", t_err_cause, 3);
        chk("t5 req dropped", t_mem_req_valid, 0);

        // response on the 8th cycle beats the timeout
        do_reset();
        t_pc_valid = 1; t_mem_req_ready = 1;
        tick();
        t_pc_valid = 0;
        tick();
        t_mem_req_ready = 0;
        for (int i = 0; i < 6; i++) tick();
        chk("t5v still wait", t_mem_rsp_ready, 1);
        t_mem_rsp_valid = 1; t_mem_rsp_data = 32'h00100073;
        tick();
        t_mem_rsp_valid = 0;
        chk("t5v inst_valid", t_inst_valid, 1);
        chk("t5v inst", t_inst, 32'h00100073);
        chk("t5v no err", t_fetch_err, 0);
        tick();
        chk("t5v no err later", t_fetch_err, 0);

        // reset mid-fetch
        do_reset();
        pc = 32'h80000000; pc_valid = 1; mem_req_ready = 1;
        tick();
        tick();
        chk("t6 in wait", mem_rsp_ready, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("t6 rst");
        tick();
        pc_valid = 0;
        chk("t6 refetch addr", mem_req_addr, 32'h80000000);
        tick();
        mem_rsp_valid = 1; mem_rsp_data = 32'h00200113;
        tick();
        mem_rsp_valid = 0;
        chk("t6 inst_valid", inst_valid, 1);
        chk("t6 inst", inst, 32'h00200113);
        chk("t6 no err", fetch_err, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
